// File: rtl/gpp_pkg.sv
// Shared definitions for the instruction fetch/issue path: opcode field layout,
// the halt opcode and the fetch FSM state encoding.
package gpp_pkg;

    localparam int OPCODE_W = 6;
    localparam int IMM_LSB  = 0;
    localparam logic [OPCODE_W-1:0] HALT_OP = 6'h3F;

    // Opcode occupies the top OPCODE_W bits; the immediate fills everything below it.
    function automatic int opcode_lsb(input int instr_w);
        return instr_w - OPCODE_W;
    endfunction

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALTED
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_next.sv
// Next-PC selection: sequential increment (wrapping at 2^ADDR_W) or branch target.
// A halting instruction always falls through, whatever the branch inputs say.
module pc_next #(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              is_halt,
    output logic [ADDR_W-1:0] next_pc
);

    assign next_pc = (branch_taken && !is_halt) ? branch_target : pc + ADDR_W'(1);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: fetches a word over a req/valid handshake into IR,
// presents opcode/imm to the control unit until it acks, then advances or branches.
module instr_fetch
    import gpp_pkg::*;
#(
    parameter int                    ADDR_W   = 10,
    parameter int                    INSTR_W  = 16,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0,
    parameter logic [OPCODE_W-1:0]   HALT_OP  = 6'h3F
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [INSTR_W-1:0]       imem_rdata,
    input  logic                     imem_valid,
    output logic [OPCODE_W-1:0]      opcode,
    output logic [INSTR_W-OPCODE_W-1:0] imm,
    output logic                     ir_valid,
    input  logic                     cu_ack,
    input  logic                     branch_taken,
    input  logic [ADDR_W-1:0]        branch_target,
    output logic [ADDR_W-1:0]        pc,
    output logic                     halted,
    output logic [15:0]              retired
);

    localparam int OP_LSB = opcode_lsb(INSTR_W);

    fetch_state_t       state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [INSTR_W-1:0] ir_q;
    logic [15:0]        retired_q;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               is_halt;

    assign opcode  = ir_q[INSTR_W-1 -: OPCODE_W];
    assign imm     = ir_q[OP_LSB-1:IMM_LSB];
    assign is_halt = (opcode == HALT_OP);

    pc_next #(
        .ADDR_W(ADDR_W)
    ) u_pc_next (
        .pc            (pc_q),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .is_halt       (is_halt),
        .next_pc       (pc_nxt)
    );

    // Stray imem_valid / cu_ack / branch_taken are only looked at in the state that expects them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (cu_ack) begin
                        retired_q <= retired_q + 16'd1;
                        pc_q      <= pc_nxt;
                        state_q   <= is_halt ? HALTED : FETCH;
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_req  = (state_q == FETCH);
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == ISSUE);
    assign halted    = (state_q == HALTED);
    assign pc        = pc_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed fetch/issue sequences push the expected
// IR contents; a monitor pops and compares each time a new instruction is presented.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic [5:0]  opcode;
    logic [9:0]  imm;
    logic        ir_valid;
    logic        cu_ack;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  pc;
    logic        halted;
    logic [15:0] retired;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [5:0] op;
        logic [9:0] imm;
        logic [9:0] pc;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_valid    (imem_valid),
        .opcode        (opcode),
        .imm           (imm),
        .ir_valid      (ir_valid),
        .cu_ack        (cu_ack),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .halted        (halted),
        .retired       (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rising ir_valid is one presented instruction.
    initial begin
        logic prev_irv;
        exp_t e;
        prev_irv = 1'b0;
        forever begin
            @(negedge clk);
            if (ir_valid === 1'b1 && prev_irv !== 1'b1) begin
                if (sbq.size() == 0) begin
                    check("unexpected_issue", 32'(opcode), 32'hFFFF_FFFF);
                end else begin
                    e = sbq.pop_front();
                    check("issue_opcode", 32'(opcode), 32'(e.op));
                    check("issue_imm",    32'(imm),    32'(e.imm));
                    check("issue_pc",     32'(pc),     32'(e.pc));
                end
            end
            prev_irv = ir_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    // All tasks start and end at a falling edge.
    task automatic serve(input logic [15:0] w, input int lat, input logic [9:0] exp_addr);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("req_seen",   32'(imem_req),  32'd1);
        check("fetch_addr", 32'(imem_addr), 32'(exp_addr));
        sbq.push_back(exp_t'{w[15:10], w[9:0], exp_addr});
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("req_hold",  32'(imem_req),  32'd1);
            check("addr_hold", 32'(imem_addr), 32'(exp_addr));
            check("no_early_ir", 32'(ir_valid), 32'd0);
        end
        imem_rdata = w;
        imem_valid = 1'b1;
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        @(negedge clk);
        check("ir_latency", 32'(ir_valid), 32'd1);
        check("req_drop",   32'(imem_req), 32'd0);
    endtask

    task automatic ack(input logic br, input logic [9:0] tgt);
        cu_ack        = 1'b1;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        #1;
        cu_ack        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 10'h000;
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        imem_rdata    = 16'h0000;
        imem_valid    = 1'b0;
        cu_ack        = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 10'h000;

        // Reset with stray memory traffic
        @(negedge clk);
        imem_valid = 1'b1;
        imem_rdata = 16'hBEEF;
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        rst = 1'b0;
        check("rst_req",     32'(imem_req), 32'd1);
        check("rst_pc",      32'(pc),       32'd0);
        check("rst_irv",     32'(ir_valid), 32'd0);
        check("rst_retired", 32'(retired),  32'd0);
        check("rst_halted",  32'(halted),   32'd0);
        check("rst_opcode",  32'(opcode),   32'd0);

        // Immediate response, immediate ack
        serve(16'h0405, 0, 10'h000);
        ack(1'b0, 10'h000);
        check("seq_irv_drop", 32'(ir_valid),  32'd0);
        check("seq_req",      32'(imem_req),  32'd1);
        check("seq_addr",     32'(imem_addr), 32'd1);
        check("seq_retired",  32'(retired),   32'd1);

        // 3-cycle latency, branch pulse without ack, then taken branch
        serve(16'h0813, 3, 10'h001);
        branch_taken  = 1'b1;
        branch_target = 10'h3C3;
        @(negedge clk);
        branch_taken  = 1'b0;
        check("br_noack_pc",  32'(pc),       32'd1);
        check("br_noack_irv", 32'(ir_valid), 32'd1);
        ack(1'b1, 10'h2A0);
        check("br_addr",    32'(imem_addr), 32'h2A0);
        check("br_retired", 32'(retired),   32'd2);

        serve(16'h0C7F, 1, 10'h2A0);
        ack(1'b1, 10'h3FF);
        check("br2_addr", 32'(imem_addr), 32'h3FF);

        // PC wrap from max address
        serve(16'h1001, 0, 10'h3FF);
        ack(1'b0, 10'h000);
        check("wrap_addr",    32'(imem_addr), 32'h000);
        check("wrap_retired", 32'(retired),   32'd4);

        // Stray ack while fetching
        cu_ack = 1'b1;
        @(negedge clk);
        cu_ack = 1'b0;
        check("stray_ack_retired", 32'(retired),  32'd4);
        check("stray_ack_req",     32'(imem_req), 32'd1);

        // Halt: branch on the halting ack is ignored
        serve(16'hFC00, 0, 10'h000);
        ack(1'b1, 10'h155);
        check("halt_flag",    32'(halted),   32'd1);
        check("halt_req",     32'(imem_req), 32'd0);
        check("halt_irv",     32'(ir_valid), 32'd0);
        check("halt_retired", 32'(retired),  32'd5);
        check("halt_pc",      32'(pc),       32'd1);
        for (int i = 0; i < 20; i++) begin
            imem_valid = i[0];
            imem_rdata = 16'h1234;
            cu_ack     = 1'b1;
            @(negedge clk);
            check("halt_req_hold", 32'(imem_req), 32'd0);
        end
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        cu_ack     = 1'b0;
        check("halt_retired_hold", 32'(retired), 32'd5);
        check("halt_ir_hold",      32'(opcode),  32'h3F);
        check("halt_flag_hold",    32'(halted),  32'd1);

        pulse_rst();
        check("rehalt_req",     32'(imem_req), 32'd1);
        check("rehalt_pc",      32'(pc),       32'd0);
        check("rehalt_halted",  32'(halted),   32'd0);
        check("rehalt_retired", 32'(retired),  32'd0);

        // Reset during ISSUE
        serve(16'h1402, 0, 10'h000);
        ack(1'b0, 10'h000);
        serve(16'h1803, 0, 10'h001);
        pulse_rst();
        check("rst_issue_pc",      32'(pc),       32'd0);
        check("rst_issue_irv",     32'(ir_valid), 32'd0);
        check("rst_issue_retired", 32'(retired),  32'd0);
        check("rst_issue_req",     32'(imem_req), 32'd1);
        check("rst_issue_ir",      32'({opcode, imm}), 32'd0);

        // Reset during FETCH with a simultaneous response
        rst        = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 16'hABCD;
        @(negedge clk);
        rst        = 1'b0;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        check("rst_fetch_ir",  32'({opcode, imm}), 32'd0);
        check("rst_fetch_irv", 32'(ir_valid), 32'd0);
        check("rst_fetch_req", 32'(imem_req), 32'd1);
        check("rst_fetch_pc",  32'(pc),       32'd0);
        @(negedge clk);
        check("rst_fetch_irv2", 32'(ir_valid), 32'd0);

        serve(16'h0405, 0, 10'h000);
        ack(1'b0, 10'h000);
        check("final_retired", 32'(retired), 32'd1);
        @(negedge clk);
        check("sb_drain", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
